xfer_sequencer: RTL and testbench
=================================

XFER_SEQUENCER -- requirements
Module: xfer_sequencer

Interface
REQ-001 The block SHALL have parameter LEN_W, default 4, giving the width of the transfer-length input; internal word counter width is LEN_W+1.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one transfer, sampled only in IDLE.
REQ-005 The block SHALL have port len, input, LEN_W bits: number of words N, sampled with start; 0 encodes 2^LEN_W.
REQ-006 The block SHALL have port pause, input, 1 bit: stall request; present only when XFER_PAUSE_EN is defined.
REQ-007 The block SHALL have port clr_addr, output, 1 bit: clears the A and B address counters.
REQ-008 The block SHALL have port WEA, output, 1 bit: write enable for memory A.
REQ-009 The block SHALL have port IncA, output, 1 bit: increment for address counter A.
REQ-010 The block SHALL have port WEB, output, 1 bit: write enable for memory B.
REQ-011 The block SHALL have port IncB, output, 1 bit: increment for address counter B.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, CLR, FILL, RWND, COPY, FLUSH and DONE, with all outputs registered.
- IDLE: start=1 -> CLR; latch N from len. start=0 -> stay in IDLE.
- CLR: clr_addr=1 for 1 cycle; word count := 0; -> FILL.
- FILL: WEA=IncA=1; count++; after N cycles -> RWND.
- RWND: clr_addr=1 for 1 cycle; count := 0; -> COPY.
- COPY: IncA=1 (read issue); count++; after N cycles -> FLUSH.
- FLUSH: last read write-back only; -> DONE.
- DONE: done=1 for 1 cycle; -> IDLE unconditionally.
REQ-015 WEB and IncB SHALL equal a one-cycle-delayed copy of the COPY read-issue strobe, modelling 1-cycle synchronous read latency of memory A.
REQ-016 With start sampled at edge 0, the timing SHALL be as follows:
- CLR in cycle 1.
- WEA in cycles 2..N+1.
- RWND in cycle N+2.
- IncA reads in cycles N+3..2N+2.
- WEB/IncB in cycles N+4..2N+3.
- done in cycle 2N+4.
- Exactly N pulses each of WEA, IncA (fill), IncA (copy), WEB and IncB.
REQ-017 start SHALL be ignored while busy=1, including in the DONE cycle.
REQ-018 len SHALL be ignored outside IDLE; a change to len mid-transfer SHALL not alter N.
REQ-019 WEA and WEB SHALL never be high in the same cycle; WEA and clr_addr SHALL never be high in the same cycle.

Reset
REQ-020 When rst=1 at a clock edge, the FSM SHALL enter IDLE and all outputs, N, the count and the WEB/IncB delay stage SHALL clear to 0.
REQ-021 rst SHALL have priority over start and pause.
REQ-022 rst asserted mid-transfer SHALL abort the transfer with no done pulse and no further strobes; a pending delayed WEB SHALL be dropped.

Configuration
REQ-023 Defining XFER_PAUSE_EN SHALL add the pause port with the following behaviour:
- In FILL or COPY with pause=1: state and count hold; WEA, IncA and the read-issue strobe are 0.
- A read issued in the cycle before pause still produces its WEB/IncB pulse.
- pause has no effect in any other state.
REQ-024 Without XFER_PAUSE_EN, the pause port and its logic SHALL be absent, and the timing SHALL be exactly as in REQ-016.

Verification
REQ-025 len=4, start pulse at cycle 0 -> WEA in cycles 2-5, clr_addr in cycles 1 and 6, IncA in cycles 7-10, WEB/IncB in cycles 8-11, done in cycle 12, busy low in cycle 13.
REQ-026 len=0 -> 16 WEA, 16 WEB, done in cycle 36.
REQ-027 len=3 transfer with start held high throughout and len changed to 7 in cycle 4 -> exactly 3 WEB pulses; new transfer begins only after returning to IDLE.
REQ-028 len=4, rst=1 in cycle 8 -> cycle 9 all outputs 0, busy=0, no done; a following start runs a full clean transfer.
REQ-029 XFER_PAUSE_EN defined, len=4, pause=1 in cycles 8-9 -> IncA in cycles 7, 10, 11, 12; WEB in cycles 8, 11, 12, 13; done in cycle 14.

Source files
------------

// File: rtl/xfer_sequencer_if.sv
// ----------------------------------------------------------------------------
// xfer_sequencer_if
// Bundles the control and strobe signals of the A->B transfer sequencer.
//
//   start    : request to begin one transfer (sampled only while idle)
//   len      : word count N, sampled with start; 0 encodes 2^LEN_W
//   pause    : stall request (only when XFER_PAUSE_EN is defined)
//   clr_addr : clear both address counters
//   WEA/IncA : memory A write enable / address A increment
//   WEB/IncB : memory B write enable / address B increment
//   busy     : high whenever the sequencer is not idle
//   done     : one-cycle completion pulse
//
// Modports: master = requester/observer, slave = sequencer.
// Optional feature macro: XFER_PAUSE_EN (adds pause).
// ----------------------------------------------------------------------------
interface xfer_sequencer_if #(
    parameter int LEN_W = 4
);
    logic             start;
    logic [LEN_W-1:0] len;
`ifdef XFER_PAUSE_EN
    logic             pause;
`endif
    logic             clr_addr;
    logic             WEA;
    logic             IncA;
    logic             WEB;
    logic             IncB;
    logic             busy;
    logic             done;

    modport master (
`ifdef XFER_PAUSE_EN
        output pause,
`endif
        output start, len,
        input  clr_addr, WEA, IncA, WEB, IncB, busy, done
    );

    modport slave (
`ifdef XFER_PAUSE_EN
        input  pause,
`endif
        input  start, len,
        output clr_addr, WEA, IncA, WEB, IncB, busy, done
    );
endinterface

// File: rtl/xfer_sequencer.sv
// ----------------------------------------------------------------------------
// xfer_sequencer
// Sequences a two-phase block transfer: fill memory A with N words, rewind the
// address counters, then copy A into B. Memory A has one cycle of synchronous
// read latency, so the B write strobes trail the A read strobes by a cycle.
//
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : xfer_sequencer_if.slave (start/len[/pause] in, strobes out)
//
// Parameter:
//   LEN_W : width of len; the word counter and latched N are LEN_W+1 bits
//
// Optional feature macro: XFER_PAUSE_EN
//   When defined, pause=1 in FILL or COPY freezes state/count and gates the
//   A strobes in that same cycle. A read already issued still writes back.
// ----------------------------------------------------------------------------
module xfer_sequencer #(
    parameter int LEN_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    xfer_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        FILL  = 3'd2,
        RWND  = 3'd3,
        COPY  = 3'd4,
        FLUSH = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [LEN_W:0] CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] CNT_ZERO = '0;

    state_t         state;
    logic [LEN_W:0] n_q;        // latched word count, 1..2^LEN_W
    logic [LEN_W:0] cnt;        // words completed in the current phase
    logic [LEN_W:0] cnt_nxt;
    logic           last_word;

    logic           clr_q;
    logic           wea_q;
    logic           inca_q;
    logic           rd_iss_q;   // COPY-phase read issue (subset of inca_q)
    logic           wb_q;       // read data returning: drives WEB and IncB
    logic           busy_q;
    logic           done_q;

    logic           stall;
    logic           rd_fire;

`ifdef XFER_PAUSE_EN
    // Pause only bites in the two streaming phases.
    assign stall = bus.pause && ((state == FILL) || (state == COPY));
`else
    assign stall = 1'b0;
`endif

    assign cnt_nxt   = cnt + CNT_ONE;
    assign last_word = (cnt_nxt == n_q);

    // A read counts as issued only if it actually left this cycle.
    assign rd_fire   = rd_iss_q && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            n_q      <= CNT_ZERO;
            cnt      <= CNT_ZERO;
            clr_q    <= 1'b0;
            wea_q    <= 1'b0;
            inca_q   <= 1'b0;
            rd_iss_q <= 1'b0;
            wb_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // Write-back stage: data read this cycle lands in B next cycle.
            wb_q <= rd_fire;

            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // len==0 yields the MSB set, i.e. 2^LEN_W.
                        n_q    <= {(bus.len == '0), bus.len};
                        state  <= CLR;
                        clr_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end

                CLR: begin
                    state  <= FILL;
                    clr_q  <= 1'b0;
                    cnt    <= CNT_ZERO;
                    wea_q  <= 1'b1;
                    inca_q <= 1'b1;
                end

                FILL: begin
                    if (!stall) begin
                        if (last_word) begin
                            state  <= RWND;
                            cnt    <= CNT_ZERO;
                            wea_q  <= 1'b0;
                            inca_q <= 1'b0;
                            clr_q  <= 1'b1;
                        end else begin
                            cnt <= cnt_nxt;
                        end
                    end
                end

                RWND: begin
                    state    <= COPY;
                    clr_q    <= 1'b0;
                    cnt      <= CNT_ZERO;
                    inca_q   <= 1'b1;
                    rd_iss_q <= 1'b1;
                end

                COPY: begin
                    if (!stall) begin
                        if (last_word) begin
                            state    <= FLUSH;
                            cnt      <= CNT_ZERO;
                            inca_q   <= 1'b0;
                            rd_iss_q <= 1'b0;
                        end else begin
                            cnt <= cnt_nxt;
                        end
                    end
                end

                // Only the trailing write-back of the final read happens here.
                FLUSH: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end

                // start is deliberately not looked at here.
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    cnt      <= CNT_ZERO;
                    clr_q    <= 1'b0;
                    wea_q    <= 1'b0;
                    inca_q   <= 1'b0;
                    rd_iss_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clr_addr = clr_q;
    assign bus.WEA      = wea_q && !stall;
    assign bus.IncA     = inca_q && !stall;
    assign bus.WEB      = wb_q;
    assign bus.IncB     = wb_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_xfer_sequencer.sv
// ----------------------------------------------------------------------------
// tb_xfer_sequencer
// Directed bench. Cycle c is the clock period that follows edge c-1; start is
// presented in cycle 0 and sampled at edge 0. Each run records every output
// as a 64-bit per-cycle trace (bit c = value in cycle c) and compares the
// traces against hand-derived masks.
// ----------------------------------------------------------------------------
module tb_xfer_sequencer;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic [63:0] t_clr, t_wea, t_inca, t_web, t_incb, t_busy, t_done;

    xfer_sequencer_if #(.LEN_W(4)) bus ();

    xfer_sequencer #(.LEN_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int c);
        t_clr[c]  = bus.clr_addr;
        t_wea[c]  = bus.WEA;
        t_inca[c] = bus.IncA;
        t_web[c]  = bus.WEB;
        t_incb[c] = bus.IncB;
        t_busy[c] = bus.busy;
        t_done[c] = bus.done;
    endtask

    // One directed transfer. chg_cyc/rst_cyc/p_lo < 0 disable that feature.
    task automatic run(input logic [3:0] l0, input bit hold, input int chg_cyc,
                       input logic [3:0] l1, input int rst_cyc,
                       input int p_lo, input int p_hi, input int ncyc);
        t_clr = '0; t_wea = '0; t_inca = '0; t_web = '0;
        t_incb = '0; t_busy = '0; t_done = '0;
        @(negedge clk);
        bus.len   = l0;
        bus.start = 1'b1;
`ifdef XFER_PAUSE_EN
        bus.pause = 1'b0;
`endif
        sample(0);
        for (int c = 1; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            bus.start = hold;
            bus.len   = (chg_cyc >= 0 && c >= chg_cyc) ? l1 : l0;
            rst       = (c == rst_cyc);
`ifdef XFER_PAUSE_EN
            bus.pause = (p_lo >= 0 && c >= p_lo && c <= p_hi);
`endif
            #1;
            sample(c);
        end
        bus.start = 1'b0;
        rst       = 1'b0;
`ifdef XFER_PAUSE_EN
        bus.pause = 1'b0;
`endif
    endtask

    // Wait (bounded) for the sequencer to return to idle.
    task automatic drain(input string tag);
        int k;
        k = 0;
        while (bus.busy === 1'b1 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, {63'b0, bus.busy}, 64'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_len4(input string pfx);
        check({pfx, "_clr"},  t_clr,  64'h0000_0042);
        check({pfx, "_wea"},  t_wea,  64'h0000_003C);
        check({pfx, "_inca"}, t_inca, 64'h0000_07BC);
        check({pfx, "_web"},  t_web,  64'h0000_0F00);
        check({pfx, "_incb"}, t_incb, 64'h0000_0F00);
        check({pfx, "_done"}, t_done, 64'h0000_1000);
        check({pfx, "_busy"}, t_busy, 64'h0000_1FFE);
        check({pfx, "_wea_web_excl"}, t_wea & t_web, 64'd0);
        check({pfx, "_wea_clr_excl"}, t_wea & t_clr, 64'd0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.len   = '0;
`ifdef XFER_PAUSE_EN
        bus.pause = 1'b0;
`endif
        // Reset state, with start asserted to confirm reset wins.
        repeat (2) @(posedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_clr",  {63'b0, bus.clr_addr}, 64'd0);
        check("rst_wea",  {63'b0, bus.WEA},      64'd0);
        check("rst_inca", {63'b0, bus.IncA},     64'd0);
        check("rst_web",  {63'b0, bus.WEB},      64'd0);
        check("rst_incb", {63'b0, bus.IncB},     64'd0);
        check("rst_busy", {63'b0, bus.busy},     64'd0);
        check("rst_done", {63'b0, bus.done},     64'd0);
        bus.start = 1'b0;
        rst       = 1'b0;
        repeat (2) @(posedge clk);

        // N=4 basic transfer.
        run(4'd4, 1'b0, -1, 4'd0, -1, -1, -1, 20);
        check_len4("len4");
        drain("len4_drain");

        // len=0 encodes 16 words; done lands in cycle 36.
        run(4'd0, 1'b0, -1, 4'd0, -1, -1, -1, 40);
        check("len0_wea_cnt",  64'($countones(t_wea)),  64'd16);
        check("len0_web_cnt",  64'($countones(t_web)),  64'd16);
        check("len0_incb_cnt", 64'($countones(t_incb)), 64'd16);
        check("len0_inca_cnt", 64'($countones(t_inca)), 64'd32);
        check("len0_done",     t_done, 64'd1 << 36);
        check("len0_busy_cnt", 64'($countones(t_busy)), 64'd36);
        check("len0_busy_end", {63'b0, t_busy[37]}, 64'd0);
        drain("len0_drain");

        // start held high, len changes to 7 in cycle 4: first transfer stays
        // N=3 (done in 10), idle in 11, second transfer starts CLR in 12.
        run(4'd3, 1'b1, 4, 4'd7, -1, -1, -1, 14);
        check("hold_web",  t_web & 64'h0000_0FFF, 64'h0000_0380);
        check("hold_clr",  t_clr,  64'h0000_1022);
        check("hold_done", t_done, 64'h0000_0400);
        check("hold_busy", t_busy, 64'h0000_37FE);
        check("hold_wea",  t_wea,  64'h0000_201C);
        drain("hold_drain");

        // Reset in cycle 8 aborts; the pending WEB from cycle 8 is dropped.
        run(4'd4, 1'b0, -1, 4'd0, 8, -1, -1, 16);
        check("abort_clr",  t_clr,  64'h0000_0042);
        check("abort_wea",  t_wea,  64'h0000_003C);
        check("abort_inca", t_inca, 64'h0000_01BC);
        check("abort_web",  t_web,  64'h0000_0100);
        check("abort_incb", t_incb, 64'h0000_0100);
        check("abort_done", t_done, 64'd0);
        check("abort_busy", t_busy, 64'h0000_01FE);
        run(4'd4, 1'b0, -1, 4'd0, -1, -1, -1, 20);
        check_len4("post_rst");
        drain("post_rst_drain");

`ifdef XFER_PAUSE_EN
        // Pause in cycles 8-9 of the copy phase.
        run(4'd4, 1'b0, -1, 4'd0, -1, 8, 9, 20);
        check("pause_inca", t_inca, 64'h0000_1CBC);
        check("pause_web",  t_web,  64'h0000_3900);
        check("pause_incb", t_incb, 64'h0000_3900);
        check("pause_done", t_done, 64'h0000_4000);
        drain("pause_drain");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
